asteroid_scheduler: RTL and testbench

Spawn controller for the asteroid movers. It owns four asteroid slots, each driving one mover's `asteroid_on`. It starts asteroids at pseudo-random gaps, retires each one when its x position passes the screen limit, and freezes with the rest of the game on `halt`. It sits between the game-state logic (`start`, `halt`, `reset`) and the four mover instances, and reports spawn events and a cleared-asteroid score.

---
 rtl/asteroid_scheduler_if.sv | 22 ++
 rtl/asteroid_scheduler.sv | 128 ++++++++++++
 tb/tb_asteroid_scheduler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/asteroid_scheduler_if.sv
// Bundles the game-state controls, mover x positions and scheduler status
// shared between the game logic and asteroid_scheduler.
interface asteroid_scheduler_if;
    logic        start;
    logic        halt;
    logic [39:0] xpos_all;
    logic [3:0]  asteroid_on;
    logic        spawn_pulse;
    logic [1:0]  spawn_slot;
    logic [2:0]  active_count;
    logic [15:0] cleared_count;

    modport master (
        output start, halt, xpos_all,
        input  asteroid_on, spawn_pulse, spawn_slot, active_count, cleared_count
    );

    modport slave (
        input  start, halt, xpos_all,
        output asteroid_on, spawn_pulse, spawn_slot, active_count, cleared_count
    );
endinterface

// File: rtl/asteroid_scheduler.sv
// Four-slot asteroid spawn controller: LFSR-randomised spawn gaps, retire on
// x limit, freeze on halt, saturating score of cleared asteroids.
module asteroid_scheduler #(
    parameter logic [23:0] MIN_GAP   = 24'd2_000_000,
    parameter logic [23:0] GAP_MASK  = 24'h7F_FFFF,
    parameter logic [9:0]  X_LIMIT   = 10'd640,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic                 clk,
    input logic                 reset,
    asteroid_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FROZEN
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  on_q, on_d;
    logic        spawn_pulse_q, spawn_pulse_d;
    logic [1:0]  spawn_slot_q, spawn_slot_d;
    logic [2:0]  active_count_q, active_count_d;
    logic [15:0] cleared_count_q, cleared_count_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [24:0] gap_cnt_q, gap_cnt_d;

    logic        work_en;
    logic [3:0]  free_mask;
    logic [1:0]  free_idx;
    logic [3:0]  retire_mask;
    logic [2:0]  retire_cnt;
    logic [16:0] cleared_sum;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d         = state_q;
        on_d            = on_q;
        spawn_pulse_d   = 1'b0;
        spawn_slot_d    = spawn_slot_q;
        active_count_d  = '0;
        cleared_count_d = cleared_count_q;
        lfsr_d          = lfsr_q;
        gap_cnt_d       = gap_cnt_q;
        free_mask       = ~on_q;
        free_idx        = '0;
        retire_mask     = '0;
        retire_cnt      = '0;
        cleared_sum     = '0;

        // A halted cycle changes nothing; the state register only tracks mode.
        work_en = (state_q != IDLE) && !bus.halt;

        case (state_q)
            IDLE:    if (bus.start && !bus.halt) state_d = RUN;
            RUN:     if (bus.halt) state_d = FROZEN;
            FROZEN:  if (!bus.halt) state_d = RUN;
            default: state_d = IDLE;
        endcase

        for (int i = 3; i >= 0; i--) begin
            if (free_mask[i]) free_idx = 2'(i);
        end

        if (work_en) begin
            for (int i = 0; i < 4; i++) begin
                if (on_q[i] && (bus.xpos_all[10*i +: 10] >= X_LIMIT)) begin
                    retire_mask[i] = 1'b1;
                    retire_cnt     = retire_cnt + 3'd1;
                end
            end
            on_d = on_q & ~retire_mask;

            // Spawn looks at the free mask from before this edge, so a slot
            // retiring now cannot be refilled in the same cycle.
            if (gap_cnt_q != '0) begin
                gap_cnt_d = gap_cnt_q - 25'd1;
            end else if (|free_mask) begin
                on_d[free_idx] = 1'b1;
                spawn_pulse_d  = 1'b1;
                spawn_slot_d   = free_idx;
                gap_cnt_d      = 25'(MIN_GAP) + 25'({8'h00, lfsr_q} & GAP_MASK);
            end

            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

            cleared_sum     = {1'b0, cleared_count_q} + 17'(retire_cnt);
            cleared_count_d = cleared_sum[16] ? 16'hFFFF : cleared_sum[15:0];
        end

        for (int i = 0; i < 4; i++) begin
            active_count_d = active_count_d + {2'b00, on_d[i]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            on_q            <= '0;
            spawn_pulse_q   <= 1'b0;
            spawn_slot_q    <= '0;
            active_count_q  <= '0;
            cleared_count_q <= '0;
            lfsr_q          <= LFSR_SEED;
            gap_cnt_q       <= 25'(MIN_GAP);
        end else begin
            state_q         <= state_d;
            on_q            <= on_d;
            spawn_pulse_q   <= spawn_pulse_d;
            spawn_slot_q    <= spawn_slot_d;
            active_count_q  <= active_count_d;
            cleared_count_q <= cleared_count_d;
            lfsr_q          <= lfsr_d;
            gap_cnt_q       <= gap_cnt_d;
        end
    end

    assign bus.asteroid_on   = on_q;
    assign bus.spawn_pulse   = spawn_pulse_q;
    assign bus.spawn_slot    = spawn_slot_q;
    assign bus.active_count  = active_count_q;
    assign bus.cleared_count = cleared_count_q;

endmodule

// File: tb/tb_asteroid_scheduler.sv
// Self-checking bench: directed scenarios plus randomised retire/halt traffic,
// every output compared each cycle against a behavioural slot/gap model.
module tb_asteroid_scheduler;

    localparam int unsigned MIN_GAP = 10;
    localparam int unsigned MASK    = 'hF;
    localparam int unsigned LIMIT   = 640;
    localparam int unsigned SEED    = 'hACE1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    asteroid_scheduler_if sif ();

    asteroid_scheduler #(
        .MIN_GAP  (24'd10),
        .GAP_MASK (24'hF),
        .X_LIMIT  (10'd640),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (sif)
    );

    // Reference model: "started" flag plus per-slot occupancy and a gap timer.
    bit          m_started;
    bit          m_on[4];
    bit          m_pulse;
    int unsigned m_slot;
    int unsigned m_gap;
    int unsigned m_lfsr;
    int unsigned m_cleared;
    int unsigned xpos[4];

    int pass_cnt  = 0;
    int total_cnt = 0;

    function automatic int unsigned lfsr_next(int unsigned l);
        int unsigned fb;
        fb = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return ((l >> 1) | (fb << 15)) & 'hFFFF;
    endfunction

    task automatic check(string tag, logic [15:0] observed, logic [15:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    endtask

    task automatic model_update(bit rst, bit st, bit hl);
        bit was_on[4];
        int first_free;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_on[i] = 1'b0;
            m_started = 1'b0;
            m_pulse   = 1'b0;
            m_slot    = 0;
            m_gap     = MIN_GAP;
            m_lfsr    = SEED;
            m_cleared = 0;
        end else if (!m_started) begin
            m_pulse = 1'b0;
            if (st && !hl) m_started = 1'b1;
        end else if (hl) begin
            m_pulse = 1'b0;
        end else begin
            was_on     = m_on;
            first_free = -1;
            for (int i = 0; i < 4; i++)
                if (!was_on[i] && first_free < 0) first_free = i;
            for (int i = 0; i < 4; i++) begin
                if (was_on[i] && xpos[i] >= LIMIT) begin
                    m_on[i]   = 1'b0;
                    m_cleared = (m_cleared == 65535) ? 65535 : m_cleared + 1;
                end
            end
            m_pulse = 1'b0;
            if (m_gap > 0) begin
                m_gap--;
            end else if (first_free >= 0) begin
                m_on[first_free] = 1'b1;
                m_pulse          = 1'b1;
                m_slot           = first_free;
                m_gap            = MIN_GAP + (m_lfsr & MASK);
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    function automatic int model_active();
        int n = 0;
        for (int i = 0; i < 4; i++) n += m_on[i];
        return n;
    endfunction

    // One clock: drive inputs, advance the model, sample outputs 1ns after the edge.
    task automatic step(bit rst, bit st, bit hl);
        logic [3:0] e_on;
        reset     = rst;
        sif.start = st;
        sif.halt  = hl;
        for (int i = 0; i < 4; i++) sif.xpos_all[10*i +: 10] = 10'(xpos[i]);
        model_update(rst, st, hl);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) e_on[i] = m_on[i];
        check("asteroid_on", {12'd0, sif.asteroid_on}, {12'd0, e_on});
        check("spawn_pulse", {15'd0, sif.spawn_pulse}, {15'd0, m_pulse});
        check("spawn_slot", {14'd0, sif.spawn_slot}, 16'(m_slot));
        check("active_count", {13'd0, sif.active_count}, 16'(model_active()));
        check("cleared_count", sif.cleared_count, 16'(m_cleared));
    endtask

    task automatic randomize_xpos(int retire_odds);
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, retire_odds - 1) == 0) xpos[i] = $urandom_range(LIMIT, 1023);
            else xpos[i] = $urandom_range(0, LIMIT - 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) xpos[i] = 0;

        // Reset and idle: nothing may spawn without start.
        step(1, 0, 0);
        step(1, 0, 0);
        for (int c = 0; c < 20; c++) step(0, 0, 0);

        // Start with halt high must not leave idle.
        step(0, 1, 1);
        for (int c = 0; c < 15; c++) step(0, 0, 0);

        // Start, then fill all four slots and leave the gap expired.
        step(0, 1, 0);
        for (int c = 0; c < 130; c++) step(0, 0, 0);
        check("all_slots_full", {13'd0, sif.active_count}, 16'd4);

        // Slot 2 crosses the limit: off next cycle, respawned the cycle after.
        xpos[2] = 640;
        step(0, 0, 0);
        xpos[2] = 0;
        check("slot2_retired", {15'd0, sif.asteroid_on[2]}, 16'd0);
        check("slot2_score", sif.cleared_count, 16'd1);
        step(0, 0, 0);
        check("slot2_respawn_pulse", {15'd0, sif.spawn_pulse}, 16'd1);
        check("slot2_respawn_slot", {14'd0, sif.spawn_slot}, 16'd2);

        // Slots 1 and 3 retire together.
        xpos[1] = 700;
        xpos[3] = 700;
        step(0, 0, 0);
        xpos[1] = 0;
        xpos[3] = 0;
        check("dual_retire_active", {13'd0, sif.active_count}, 16'd2);
        check("dual_retire_score", sif.cleared_count, 16'd3);

        // Halt for 50 cycles in the middle of a gap.
        for (int c = 0; c < 4; c++) step(0, 0, 0);
        for (int c = 0; c < 50; c++) step(0, 0, 1);
        for (int c = 0; c < 80; c++) step(0, 0, 0);

        // Randomised retire and halt traffic.
        for (int c = 0; c < 3000; c++) begin
            randomize_xpos(40);
            step(0, $urandom_range(0, 1), $urandom_range(0, 19) == 0);
        end

        // Reset mid-flight, ideally with three slots active.
        for (int c = 0; c < 500 && model_active() != 3; c++) begin
            randomize_xpos(40);
            step(0, 0, 0);
        end
        for (int i = 0; i < 4; i++) xpos[i] = 0;
        step(1, 0, 0);
        check("reset_clears_slots", {12'd0, sif.asteroid_on}, 16'd0);
        check("reset_clears_score", sif.cleared_count, 16'd0);
        for (int c = 0; c < 30; c++) step(0, 0, 0);

        // Restart and run randomised traffic again, including long halts.
        step(0, 1, 0);
        for (int c = 0; c < 1500; c++) begin
            randomize_xpos(30);
            step(0, 0, ($urandom_range(0, 199) < 3) || (c % 400 >= 380));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
